// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets after a reset event, then releases
// them one stage at a time; re-enters on software request or watchdog timeout.
module rst_seq_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_STAGES  = 3,
  parameter int WDT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_rst_req_i,
  input  logic                  wdt_en_i,
  input  logic                  wdt_kick_i,
  input  logic [WDT_WIDTH-1:0]  wdt_limit_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  all_released_o,
  output logic                  busy_o,
  output logic [1:0]            rst_cause_o,
  output logic [1:0]            state_o
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int GW = $clog2(STAGE_GAP) + 1;
  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_DONE = SW'(NUM_STAGES);

  localparam logic [1:0] CAUSE_EXT = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [SW-1:0]         stage_idx_q, stage_idx_d;
  logic [WDT_WIDTH-1:0]  wdt_cnt_q, wdt_cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [1:0]            rst_cause_q, rst_cause_d;
  logic                  wdt_active;
  logic                  wdt_timeout;
  logic                  sw_trigger;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    stage_rst_d = stage_rst_q;
    rst_cause_d = rst_cause_q;
    wdt_cnt_d   = '0;

    wdt_active  = (state_q == ST_RUN) && wdt_en_i && (wdt_limit_i != '0);
    wdt_timeout = wdt_active && !wdt_kick_i && (wdt_cnt_q == wdt_limit_i);
    // Software requests only restart a sequence that has begun releasing.
    sw_trigger  = sw_rst_req_i && (state_q != ST_ASSERT);

    if (wdt_active) begin
      if (wdt_kick_i) begin
        wdt_cnt_d = '0;
      end else if (wdt_cnt_q != '1) begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q;
      end
    end

    case (state_q)
      ST_ASSERT: begin
        stage_rst_d = '1;
        if (hold_cnt_q == HOLD_LAST) begin
          stage_rst_d[0] = 1'b0;
          state_d        = ST_RELEASE;
          gap_cnt_d      = '0;
          stage_idx_d    = SW'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stage_idx_q == STAGE_DONE) begin
          state_d = ST_RUN;
        end else if (gap_cnt_q == GAP_LAST) begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (SW'(k) == stage_idx_q) stage_rst_d[k] = 1'b0;
          end
          gap_cnt_d   = '0;
          stage_idx_d = stage_idx_q + 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        stage_rst_d = '0;
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    if (wdt_timeout || sw_trigger) begin
      state_d     = ST_ASSERT;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      stage_idx_d = '0;
      wdt_cnt_d   = '0;
      stage_rst_d = '1;
      rst_cause_d = wdt_timeout ? CAUSE_WDT : CAUSE_SW;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      wdt_cnt_q   <= '0;
      stage_rst_q <= '1;
      rst_cause_q <= CAUSE_EXT;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      wdt_cnt_q   <= wdt_cnt_d;
      stage_rst_q <= stage_rst_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  assign stage_rst_o    = stage_rst_q;
  assign all_released_o = (state_q == ST_RUN);
  assign busy_o         = (state_q != ST_RUN);
  assign rst_cause_o    = rst_cause_q;
  assign state_o        = state_q;

endmodule
